// File: rtl/vector_result_serializer.sv
// rtl/vector_result_serializer.sv - snapshots Q lanes of acc/ai results and streams them as 2Q words
// Optional drop counter built only when RESULT_SERIALIZER_DROP_CNT_EN is defined.
module vector_result_serializer #(
  parameter int Q     = 4,
  parameter int IDX_W = $clog2(2*Q)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic [Q-1:0][31:0]  acc_in,
  input  logic [Q-1:0][31:0]  ai_in,
  output logic [31:0]         m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IDX_W-1:0]    m_idx,
  output logic                m_last,
  output logic                busy,
  output logic [15:0]         drop_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_ACC = 2'd1;
  localparam logic [1:0] SEND_AI  = 2'd2;

  localparam logic [IDX_W-1:0] ACC_END   = IDX_W'(Q - 1);
  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(2*Q - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [2*Q-1:0][31:0]    frame_q, frame_d;
  logic                    accept;
  logic                    last_accept;
  logic                    take;

  // A capture landing on the final handshake starts the next frame with no idle gap.
  always_comb begin
    accept      = (state_q != IDLE) && m_ready;
    last_accept = accept && (state_q == SEND_AI) && (idx_q == FRAME_END);
    take        = capture && ((state_q == IDLE) || last_accept);
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    if (accept) begin
      idx_d = idx_q + IDX_W'(1);
      if ((state_q == SEND_ACC) && (idx_q == ACC_END)) begin
        state_d = SEND_AI;
      end
      if (last_accept) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
    if (take) begin
      state_d = SEND_ACC;
      idx_d   = '0;
      for (int i = 0; i < Q; i++) begin
        frame_d[i]     = acc_in[i];
        frame_d[Q + i] = ai_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign m_valid = busy;
  assign m_idx   = idx_q;
  assign m_data  = busy ? frame_q[idx_q] : 32'd0;
  assign m_last  = (state_q == SEND_AI) && (idx_q == FRAME_END);

`ifdef RESULT_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (capture && busy && !last_accept && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vector_result_serializer.sv
// tb/tb_vector_result_serializer.sv - directed and random checks of vector_result_serializer against a frame-queue model
module tb_vector_result_serializer;

  localparam int Q     = 4;
  localparam int W     = 2*Q;
  localparam int IDX_W = $clog2(2*Q);

  logic               clk = 1'b0;
  logic               rst;
  logic               capture;
  logic [Q-1:0][31:0] acc_in;
  logic [Q-1:0][31:0] ai_in;
  logic [31:0]        m_data;
  logic               m_valid;
  logic               m_ready;
  logic [IDX_W-1:0]   m_idx;
  logic               m_last;
  logic               busy;
  logic [15:0]        drop_cnt;

  always #5 clk = ~clk;

  vector_result_serializer #(.Q(Q)) dut (
    .clk(clk), .rst(rst), .capture(capture), .acc_in(acc_in), .ai_in(ai_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: the frame as a flat word list, how many words are sent, and drop tally.
  logic [31:0] mf [W];
  int          pos   = 0;
  bit          mbusy = 0;
  int unsigned mdrop = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < Q; i++) begin
      acc_in[i] = $urandom;
      ai_in[i]  = $urandom;
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", 32'(m_valid), 32'(mbusy));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("m_last", 32'(m_last), 32'(mbusy && pos == W-1));
    if (mbusy) begin
      chk("m_idx", 32'(m_idx), 32'(pos));
      chk("m_data", m_data, mf[pos]);
    end
`ifdef RESULT_SERIALIZER_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), mdrop);
`else
    chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
  endtask

  task automatic step(bit cap, bit rdy, bit r, bit do_check);
    bit fin;
    capture = cap;
    m_ready = rdy;
    rst     = r;
    @(posedge clk);
    if (r) begin
      mbusy = 0;
      pos   = 0;
      mdrop = 0;
    end else begin
      fin = mbusy && rdy && (pos == W-1);
      if (mbusy && rdy) pos++;
      if (fin) mbusy = 0;
      if (cap) begin
        if (!mbusy) begin
          for (int i = 0; i < Q; i++) begin
            mf[i]     = acc_in[i];
            mf[Q + i] = ai_in[i];
          end
          pos   = 0;
          mbusy = 1;
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
    end
    #1;
    capture = 1'b0;
    if (do_check) check_outputs();
    randomize_data();
  endtask

  initial begin
    rst = 1'b1; capture = 1'b0; m_ready = 1'b0;
    randomize_data();

    // reset, including a capture that must be ignored
    step(0, 0, 1, 1);
    step(1, 1, 1, 1);
    chk("reset_m_data", m_data, 32'd0);
    chk("reset_m_idx", 32'(m_idx), 32'd0);

    // fixed frame, ready held high
    for (int i = 0; i < Q; i++) begin
      acc_in[i] = 32'(i + 1);
      ai_in[i]  = 32'((i + 1) * 10);
    end
    step(1, 1, 0, 1);
    for (int k = 0; k < W; k++) step(0, 1, 0, 1);
    chk("idle_after_frame", 32'(busy), 32'd0);

    // backpressure for 3 cycles at word 2
    step(1, 1, 0, 1);
    for (int k = 0; k < 20 && pos != 2; k++) step(0, 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    for (int k = 0; k < 20 && mbusy; k++) step(0, 1, 0, 1);

    // capture mid-frame is dropped
    step(1, 1, 0, 1);
    for (int k = 0; k < 20 && pos != 3; k++) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    for (int k = 0; k < 20 && mbusy; k++) step(0, 1, 0, 1);

    // capture on the last handshake chains frames
    step(1, 1, 0, 1);
    for (int k = 0; k < 20 && pos != W-1; k++) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("chain_idx0", 32'(m_idx), 32'd0);
    chk("chain_valid", 32'(m_valid), 32'd1);

    // reset mid-frame at word 5, then restart
    for (int k = 0; k < 20 && pos != 5; k++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(1, 1, 0, 1);
    chk("restart_idx0", 32'(m_idx), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 0, 1);
    for (int k = 0; k < 40 && mbusy; k++) step(0, 1, 0, 1);

`ifdef RESULT_SERIALIZER_DROP_CNT_EN
    // drop counter saturation
    step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 65537; k++) step(1, 0, 0, 0);
    check_outputs();
    chk("drop_saturated", 32'(drop_cnt), 32'd65535);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
